// File: rtl/return_address_stack.sv
// Circular return address stack predicting JALR return targets, with checkpoint/restore.
// Optional overflow counter enabled by defining FROST_RAS_OVERFLOW_COUNTER_EN.
module return_address_stack #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 8
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_stall,
   input  logic                       i_push,
   input  logic [XLEN-1:0]            i_push_addr,
   input  logic                       i_pop,
   output logic [XLEN-1:0]            o_predicted_target,
   output logic                       o_valid,
   output logic [$clog2(DEPTH)-1:0]   o_checkpoint_tos,
   output logic [$clog2(DEPTH):0]     o_checkpoint_count,
   input  logic                       i_restore,
   input  logic [$clog2(DEPTH)-1:0]   i_restore_tos,
   input  logic [$clog2(DEPTH):0]     i_restore_count,
   output logic [15:0]                o_overflow_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [XLEN-1:0] entry [DEPTH];
   logic [PW-1:0]   tos;
   logic [CW-1:0]   count;

   logic            active;
   logic            push_only;
   logic            pop_only;
   logic            swap;
   logic [PW-1:0]   tos_inc;
   logic [PW-1:0]   tos_dec;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      active    = 1'b0;
      push_only = 1'b0;
      pop_only  = 1'b0;
      swap      = 1'b0;
      tos_inc   = tos + PW'(1);
      tos_dec   = tos - PW'(1);
      active    = !i_restore && !i_stall;
      push_only = active && i_push && !i_pop;
      pop_only  = active && i_pop && !i_push;
      swap      = active && i_push && i_pop;
   end

   // NOTE: the entry array is reset because a zero predicted target after reset is part of the contract.
   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < DEPTH; i++) entry[i] <= '0;
         tos   <= '0;
         count <= '0;
      end else if (i_restore) begin
         tos   <= i_restore_tos;
         count <= i_restore_count;
      end else if (push_only) begin
         tos            <= tos_inc;
         entry[tos_inc] <= i_push_addr;
         if (count != FULL) count <= count + CW'(1);
      end else if (pop_only && count != '0) begin
         tos   <= tos_dec;
         count <= count - CW'(1);
      end else if (swap) begin
         entry[tos] <= i_push_addr;
      end
   end

   assign o_predicted_target = entry[tos];
   assign o_valid            = (count != '0);
   assign o_checkpoint_tos   = tos;
   assign o_checkpoint_count = count;

`ifdef FROST_RAS_OVERFLOW_COUNTER_EN
   logic [15:0] overflow_count;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         overflow_count <= '0;
      end else if (push_only && count == FULL && overflow_count != 16'hFFFF) begin
         overflow_count <= overflow_count + 16'd1;
      end
   end

   assign o_overflow_count = overflow_count;
`else
   assign o_overflow_count = '0;
`endif

endmodule

// File: tb/tb_return_address_stack.sv
// Scoreboard bench for return_address_stack (DEPTH = 8): a reference model queues expected
// state per driven cycle, compared one cycle later, plus directed constant checks.
module tb_return_address_stack;

   localparam int XLEN  = 32;
   localparam int DEPTH = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              stall = 1'b0;
   logic              push = 1'b0;
   logic [XLEN-1:0]   push_addr = '0;
   logic              pop = 1'b0;
   logic [XLEN-1:0]   predicted_target;
   logic              valid;
   logic [2:0]        checkpoint_tos;
   logic [3:0]        checkpoint_count;
   logic              restore = 1'b0;
   logic [2:0]        restore_tos = '0;
   logic [3:0]        restore_count = '0;
   logic [15:0]       overflow_count;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] target;
      logic [31:0] valid;
      logic [31:0] tos;
      logic [31:0] count;
      logic [31:0] ovf;
   } expect_t;

   expect_t sb[$];

   logic [31:0] m_entry [DEPTH];
   int          m_tos;
   int          m_count;
   int          m_ovf;

   logic [31:0] saved_tos;
   logic [31:0] saved_count;

   return_address_stack #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
      .i_clk              (clk),
      .i_rst              (rst),
      .i_stall            (stall),
      .i_push             (push),
      .i_push_addr        (push_addr),
      .i_pop              (pop),
      .o_predicted_target (predicted_target),
      .o_valid            (valid),
      .o_checkpoint_tos   (checkpoint_tos),
      .o_checkpoint_count (checkpoint_count),
      .i_restore          (restore),
      .i_restore_tos      (restore_tos),
      .i_restore_count    (restore_count),
      .o_overflow_count   (overflow_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) m_entry[i] = '0;
      m_tos   = 0;
      m_count = 0;
      m_ovf   = 0;
   endtask

   function automatic expect_t model_view();
      expect_t e;
      e.target = m_entry[m_tos];
      e.valid  = (m_count != 0) ? 32'd1 : 32'd0;
      e.tos    = m_tos;
      e.count  = m_count;
`ifdef FROST_RAS_OVERFLOW_COUNTER_EN
      e.ovf    = m_ovf;
`else
      e.ovf    = 0;
`endif
      return e;
   endfunction

   // Drive one cycle, advance the model, queue its view, then compare after the edge.
   task automatic step(input logic p, input logic [31:0] a, input logic q, input logic s,
                       input logic r, input int rt, input int rc, input string tag);
      expect_t e;
      push = p; push_addr = a; pop = q; stall = s;
      restore = r; restore_tos = 3'(rt); restore_count = 4'(rc);
      if (r) begin
         m_tos = rt; m_count = rc;
      end else if (!s) begin
         if (p && q) begin
            m_entry[m_tos] = a;
         end else if (p) begin
            if (m_count == DEPTH) begin
               if (m_ovf < 16'hFFFF) m_ovf++;
            end else begin
               m_count++;
            end
            m_tos = (m_tos + 1) % DEPTH;
            m_entry[m_tos] = a;
         end else if (q && m_count > 0) begin
            m_tos = (m_tos + DEPTH - 1) % DEPTH;
            m_count--;
         end
      end
      sb.push_back(model_view());
      @(posedge clk);
      #1;
      push = 1'b0; pop = 1'b0; stall = 1'b0; restore = 1'b0;
      e = sb.pop_front();
      check({tag, ".target"}, predicted_target, e.target);
      check({tag, ".valid"}, {31'd0, valid}, e.valid);
      check({tag, ".tos"}, {29'd0, checkpoint_tos}, e.tos);
      check({tag, ".count"}, {28'd0, checkpoint_count}, e.count);
      check({tag, ".ovf"}, {16'd0, overflow_count}, e.ovf);
   endtask

   task automatic do_push(input logic [31:0] a, input string tag);
      step(1'b1, a, 1'b0, 1'b0, 1'b0, 0, 0, tag);
   endtask

   task automatic do_pop(input string tag);
      step(1'b0, '0, 1'b1, 1'b0, 1'b0, 0, 0, tag);
   endtask

   initial begin
      model_reset();
      #12;
      check("reset.target", predicted_target, 32'h0);
      check("reset.valid", {31'd0, valid}, 32'd0);
      check("reset.ovf", {16'd0, overflow_count}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      check("post_reset.valid", {31'd0, valid}, 32'd0);

      // LIFO order
      do_push(32'h100, "lifo_push0");
      do_push(32'h200, "lifo_push1");
      do_push(32'h300, "lifo_push2");
      check("lifo_top300", predicted_target, 32'h300);
      do_pop("lifo_pop0");
      check("lifo_top200", predicted_target, 32'h200);
      do_pop("lifo_pop1");
      check("lifo_top100", predicted_target, 32'h100);
      do_pop("lifo_pop2");
      check("lifo_empty", {31'd0, valid}, 32'd0);

      // Underflow and swap
      do_pop("underflow");
      check("underflow.valid", {31'd0, valid}, 32'd0);
      check("underflow.count", {28'd0, checkpoint_count}, 32'd0);
      step(1'b1, 32'h555, 1'b1, 1'b0, 1'b0, 0, 0, "swap_empty");
      check("swap_empty.valid", {31'd0, valid}, 32'd0);
      do_push(32'h100, "swap_pre0");
      do_push(32'h200, "swap_pre1");
      check("swap_pre_top", predicted_target, 32'h200);
      step(1'b1, 32'h444, 1'b1, 1'b0, 1'b0, 0, 0, "swap");
      check("swap_top444", predicted_target, 32'h444);
      check("swap_count", {28'd0, checkpoint_count}, 32'd2);

      // Checkpoint/restore: set tos=7,count=0 so three pushes reach tos=2,count=3
      step(1'b0, '0, 1'b0, 1'b0, 1'b1, 7, 0, "ckpt_setup");
      do_push(32'hA10, "ckpt_push0");
      do_push(32'hA20, "ckpt_push1");
      do_push(32'hA30, "ckpt_push2");
      saved_tos   = {29'd0, checkpoint_tos};
      saved_count = {28'd0, checkpoint_count};
      check("ckpt_tos", saved_tos, 32'd2);
      check("ckpt_count", saved_count, 32'd3);
      do_push(32'hAAA, "ckpt_pushA");
      do_pop("ckpt_pop0");
      do_pop("ckpt_pop1");
      step(1'b1, 32'hBAD, 1'b0, 1'b1, 1'b1, int'(saved_tos), int'(saved_count), "restore");
      check("restore_tos", {29'd0, checkpoint_tos}, 32'd2);
      check("restore_count", {28'd0, checkpoint_count}, 32'd3);
      check("restore_target", predicted_target, 32'hA30);

      // Stall holds state while push is asserted
      for (int i = 0; i < 4; i++) step(1'b1, 32'hC00, 1'b0, 1'b1, 1'b0, 0, 0, "stall");
      check("stall_count", {28'd0, checkpoint_count}, 32'd3);
      do_push(32'hC00, "stall_release");
      check("stall_release_top", predicted_target, 32'hC00);

      // Overflow wrap from a clean stack
      rst = 1'b1; #2; rst = 1'b0;
      model_reset();
      @(posedge clk); #1;
      for (int i = 1; i <= 9; i++) do_push(32'(i * 16), "ovf_push");
      check("ovf_count", {28'd0, checkpoint_count}, 32'd8);
      check("ovf_top", predicted_target, 32'h90);
`ifdef FROST_RAS_OVERFLOW_COUNTER_EN
      check("ovf_counter", {16'd0, overflow_count}, 32'd1);
`else
      check("ovf_counter", {16'd0, overflow_count}, 32'd0);
`endif
      for (int i = 0; i < 8; i++) begin
         check("ovf_pop_value", predicted_target, 32'(32'h90 - i * 16));
         do_pop("ovf_pop");
      end
      check("ovf_drained", {31'd0, valid}, 32'd0);

      // Asynchronous reset mid-stream
      do_push(32'hDEAD, "mid_push0");
      do_push(32'hBEEF, "mid_push1");
      #2 rst = 1'b1;
      #1;
      check("async_rst.target", predicted_target, 32'h0);
      check("async_rst.valid", {31'd0, valid}, 32'd0);
      check("async_rst.count", {28'd0, checkpoint_count}, 32'd0);
      check("async_rst.tos", {29'd0, checkpoint_tos}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      @(posedge clk); #1;
      check("async_rel.valid", {31'd0, valid}, 32'd0);
      do_push(32'h1234, "after_rst_push");
      do_pop("after_rst_pop");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
